frame_buffer_ctrl: RTL
======================

Name: frame_buffer_ctrl

Overview:
- Parametrised capture/readout controller between the camera pixel stream and a single-port image BRAM.
- Arms on a take-photo command and writes exactly one frame of DEPTH pixels, starting at the next frame_start.
- On a read command it scans the whole buffer, streams each word out with a valid strobe, and counts pixels above a programmable threshold.
- Supersedes the fixed 10-bit/16-bit capture + photo FSM pairing; a single owner drives the BRAM port, so no external mux is needed.

Parameters:
- DATA_W, 16: pixel/BRAM word width.
- DEPTH, 784: pixels per frame (28x28); BRAM words used.
- ADDR_W, 10: BRAM address width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LAT, 1: BRAM read latency in cycles; legal values 1 or 2.
- CNT_W, 10: width of the above-threshold count; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- reset_n  in  1  synchronous, active-low reset.
- take_photo  in  1  single-cycle capture command.
- read_start  in  1  single-cycle readout command.
- frame_start  in  1  single-cycle pulse at the start of each camera frame.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_data  in  DATA_W  incoming pixel.
- threshold  in  DATA_W  compare value; sampled on the accepted read_start.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, RD_LAT cycles after the address.
- busy  out  1  high in any non-IDLE state.
- frame_done  out  1  sticky: capture complete.
- short_frame  out  1  sticky: a restart occurred during the last capture.
- rd_valid  out  1  rd_data/rd_addr valid.
- rd_data  out  DATA_W  readout pixel.
- rd_addr  out  ADDR_W  address of rd_data.
- read_done  out  1  one-cycle pulse at the end of the scan.
- count  out  CNT_W  pixels with value > threshold; held stable.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; all outputs 0, including count, frame_done and short_frame.
  - Reset mid-operation aborts immediately; no further mem_we.
- States: IDLE, ARM, CAPTURE, READ, DRAIN.
- IDLE:
  - take_photo -> ARM; clears frame_done and short_frame.
  - Otherwise read_start -> READ; latches threshold, clears count, waddr/raddr = 0.
  - Both in the same cycle: take_photo wins and read_start is dropped.
- Commands in any non-IDLE state are ignored.
- ARM: waits for frame_start; pix_valid is ignored. frame_start -> CAPTURE with waddr = 0.
- CAPTURE, pix_valid cycle: mem_en = mem_we = 1, mem_addr = waddr, mem_wdata = pix_data (combinational, same cycle); waddr increments.
  - Write of waddr == DEPTH-1 -> IDLE and set frame_done, effective the next cycle.
  - Cycles without pix_valid: mem_en = mem_we = 0.
- frame_start in CAPTURE before DEPTH writes: set short_frame, waddr = 0, stay in CAPTURE (overwrite from the new frame).
  - If frame_start and pix_valid coincide, that pixel is written to address 0 and waddr becomes 1.
- Pixels after the last write are never written (no wrap past DEPTH-1).
- READ: every cycle mem_en = 1, mem_we = 0, mem_addr = raddr; raddr increments.
  - After issuing DEPTH-1 -> DRAIN.
- Valid pipeline: an RD_LAT-deep shift of (valid, addr).
  - rd_valid is high exactly RD_LAT cycles after each issue; rd_data = mem_rdata, rd_addr = delayed address.
  - rd_valid is high for exactly DEPTH cycles, gapless.
- Counting: on each rd_valid cycle with mem_rdata > threshold (unsigned), count increments.
  - Never saturates, because CNT_W covers DEPTH.
- DRAIN: waits for the pipeline to empty, then pulses read_done one cycle after the last rd_valid, -> IDLE.
  - count holds its final value until the next accepted read_start.
- Address arithmetic is ADDR_W unsigned; comparisons use DEPTH-1 exactly. DEPTH < 2**ADDR_W leaves upper words untouched.
- frame_done stays high until the next accepted take_photo or reset.

Test Plan:
- Reset released, no stimulus -> all outputs 0, busy = 0; after 784 pix_valid pulses without commands, mem_we never asserts.
- take_photo, 5 idle cycles, frame_start, 784 pix_valid with pix_data = index -> writes 0..783 at addresses 0..783; frame_done rises the cycle after the last write; busy = 0; extra pixels not written.
- Capture, then frame_start after 100 pixels -> short_frame = 1; writes restart at address 0; completes after 784 further pixels.
- read_start with threshold = 0x0200 over the buffer holding 0..783, RD_LAT = 1 and 2 -> 784 gapless rd_valid, rd_addr 0..783 in order; count = 271; read_done single pulse; count held afterwards.
- take_photo and read_start in the same cycle -> ARM entered, no read; read_start during CAPTURE ignored.
- reset_n low mid-CAPTURE at address 300 -> next cycle IDLE, mem_we = 0, frame_done = 0, no further writes.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - camera frame capture into a single-port BRAM and thresholded readout scan
module frame_buffer_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_photo,
    input  logic              read_start,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [DATA_W-1:0] threshold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              read_done,
    output logic [CNT_W-1:0]  count
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, READ, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] waddr, raddr, wr_addr;
    logic [DATA_W-1:0] thr_q;
    logic [RD_LAT-1:0] vpipe;
    logic [ADDR_W-1:0] apipe [RD_LAT];

    // A frame_start mid-capture restarts the frame; a coincident pixel lands at address 0.
    assign wr_addr   = frame_start ? '0 : waddr;
    assign busy      = (state != IDLE);
    assign rd_valid  = vpipe[RD_LAT-1];
    assign rd_addr   = rd_valid ? apipe[RD_LAT-1] : '0;
    assign rd_data   = rd_valid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        read_done = 1'b0;
        case (state)
            IDLE: begin
                if (take_photo) begin
                    state_nxt = ARM;
                end else if (read_start) begin
                    state_nxt = READ;
                end
            end
            ARM: begin
                if (frame_start) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (pix_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = pix_data;
                    if (wr_addr == LAST) state_nxt = IDLE;
                end
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = raddr;
                if (raddr == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (vpipe == '0) begin
                    read_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            waddr       <= '0;
            raddr       <= '0;
            thr_q       <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            count       <= '0;
            vpipe       <= '0;
            for (int i = 0; i < RD_LAT; i++) apipe[i] <= '0;
        end else begin
            // Issue tags travel alongside the BRAM read latency.
            vpipe[0] <= (state == READ);
            apipe[0] <= raddr;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                apipe[i] <= apipe[i-1];
            end
            if (rd_valid && (mem_rdata > thr_q)) count <= count + 1'b1;
            case (state)
                IDLE: begin
                    if (take_photo) begin
                        frame_done  <= 1'b0;
                        short_frame <= 1'b0;
                    end else if (read_start) begin
                        thr_q <= threshold;
                        count <= '0;
                        raddr <= '0;
                    end
                end
                ARM: begin
                    if (frame_start) waddr <= '0;
                end
                CAPTURE: begin
                    if (frame_start) short_frame <= 1'b1;
                    if (pix_valid) begin
                        waddr <= wr_addr + 1'b1;
                        if (wr_addr == LAST) frame_done <= 1'b1;
                    end else if (frame_start) begin
                        waddr <= '0;
                    end
                end
                READ: raddr <= raddr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
